// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;
  localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

  // Controller states. CAPTURE is the cycle in which the memory word is
  // sampled; STALL holds the captured address until the queue has room.
  typedef enum logic [1:0] {
    WAIT    = 2'd0,
    CAPTURE = 2'd1,
    STALL   = 2'd2,
    HALT    = 2'd3
  } fetch_state_e;

  // One fetched instruction together with the byte address it came from.
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // True when an address lies at or beyond the end of program memory.
  function automatic logic pastEnd(input logic [ADDR_W-1:0] addr,
                                   input logic [ADDR_W-1:0] memBytes);
    return (addr >= memBytes);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry synchronous FIFO holding fetched instructions for decode.
// The head entry is a register, so its fields drive decode directly.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  fetch_entry_t pushEntry_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic         full_o,
  output logic         empty_o,
  output fetch_entry_t head_o
);

  localparam logic [1:0] FULL_CNT = 2'(QDEPTH);

  fetch_entry_t head_q, head_d;
  fetch_entry_t tail_q, tail_d;
  logic [1:0]   count_q, count_d;
  logic         doPop;
  logic         doPush;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == 2'd0);
  assign head_o  = head_q;

  // Work out the next queue contents: flush wins, a pop on an empty queue is
  // ignored, and a push into a full queue only lands when a pop frees a slot.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    doPop   = pop_i && !empty_o;
    doPush  = push_i && (!full_o || doPop);
    if (flush_i) begin
      count_d = 2'd0;
    end else if (doPop && doPush) begin
      if (count_q == FULL_CNT) begin
        head_d = tail_q;
        tail_d = pushEntry_i;
      end else begin
        head_d = pushEntry_i;
      end
    end else if (doPop) begin
      head_d  = tail_q;
      count_d = count_q - 2'd1;
    end else if (doPush) begin
      if (empty_o) begin
        head_d = pushEntry_i;
      end else begin
        tail_d = pushEntry_i;
      end
      count_d = count_q + 2'd1;
    end
  end

  // Queue storage with synchronous reset to an empty, zeroed state.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, waits out the instruction memory read delay,
// queues fetched words for decode and handles redirects and end of memory.
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = 32'h0,
  parameter int                RD_WAIT   = 2,
  parameter logic [ADDR_W-1:0] MEM_BYTES = 32'd40,
  parameter int                QDEPTH    = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  input  logic               out_ready,
  output logic               halted
);

  localparam int CNT_W = $clog2(RD_WAIT + 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(RD_WAIT - 1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  waitCnt_q, waitCnt_d;

  logic [ADDR_W-1:0] pcNext;
  logic [ADDR_W-1:0] redirectTarget;
  logic              qFull;
  logic              qEmpty;
  logic              qPop;
  logic              qPush;
  logic              qFlush;
  logic              canPush;
  fetch_entry_t      qHead;
  fetch_entry_t      pushEntry;

  assign pcNext         = pc_q + PC_STEP;
  assign redirectTarget = redirect_pc & ~32'h3;
  assign qPop           = out_ready && !redirect_valid;
  assign canPush        = !qFull || (!qEmpty && out_ready);
  assign pushEntry      = '{pc: pc_q, instr: imem_instr};

  assign imem_addr = pc_q;
  assign out_valid = !qEmpty;
  assign out_pc    = qHead.pc;
  assign out_instr = qHead.instr;

  // State, PC and wait counter registers; reset may land directly in HALT
  // when the reset PC is already past the end of program memory.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= pastEnd(RESET_PC, MEM_BYTES) ? HALT : WAIT;
      pc_q      <= RESET_PC;
      waitCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      waitCnt_q <= waitCnt_d;
    end
  end

  // Next-state selection; a redirect overrides whatever the FSM was doing.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT: begin
        if (waitCnt_q == LAST_WAIT) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE, STALL: begin
        if (canPush) begin
          state_d = pastEnd(pcNext, MEM_BYTES) ? HALT : WAIT;
        end else begin
          state_d = STALL;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = WAIT;
      end
    endcase
    if (redirect_valid) begin
      state_d = pastEnd(redirectTarget, MEM_BYTES) ? HALT : WAIT;
    end
  end

  // Per-state actions: count the read delay, push captured words and
  // advance the PC, or reload everything from a redirect target.
  always_comb begin
    qPush     = 1'b0;
    qFlush    = redirect_valid;
    pc_d      = pc_q;
    waitCnt_d = waitCnt_q;
    halted    = (state_q == HALT);
    if (redirect_valid) begin
      pc_d      = redirectTarget;
      waitCnt_d = '0;
    end else begin
      unique case (state_q)
        WAIT: begin
          waitCnt_d = waitCnt_q + 1'b1;
        end
        CAPTURE, STALL: begin
          if (canPush) begin
            qPush     = 1'b1;
            pc_d      = pcNext;
            waitCnt_d = '0;
          end
        end
        default: begin
          qPush = 1'b0;
        end
      endcase
    end
  end

  fetch_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk         (clk),
    .reset       (reset),
    .push_i      (qPush),
    .pushEntry_i (pushEntry),
    .pop_i       (qPop),
    .flush_i     (qFlush),
    .full_o      (qFull),
    .empty_o     (qEmpty),
    .head_o      (qHead)
  );

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl. Two instances share the stimulus:
// one with the default 40-byte memory and one with a 12-byte memory so the
// end-of-program halt can be observed alongside normal fetching.
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        outReady;
  logic        redirectValid;
  logic [31:0] redirectPc;

  logic [31:0] imemAddr, imemInstr, outInstr, outPc;
  logic        outValid, halted;

  logic [31:0] imemAddrSmall, imemInstrSmall, outInstrSmall, outPcSmall;
  logic        outValidSmall, haltedSmall;

  int errors = 0;
  int checks = 0;

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Program image: three known words, then an address-tagged filler.
  function automatic logic [31:0] memWord(input logic [31:0] addr);
    case (addr[31:2])
      30'd0:   return 32'h5800000F;
      30'd1:   return 32'h58080010;
      30'd2:   return 32'h10009000;
      default: return 32'hC0DE0000 | addr;
    endcase
  endfunction

  assign imemInstr      = memWord(imemAddr);
  assign imemInstrSmall = memWord(imemAddrSmall);

  instr_fetch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imemAddr),
    .imem_instr     (imemInstr),
    .redirect_valid (redirectValid),
    .redirect_pc    (redirectPc),
    .out_valid      (outValid),
    .out_instr      (outInstr),
    .out_pc         (outPc),
    .out_ready      (outReady),
    .halted         (halted)
  );

  instr_fetch_ctrl #(
    .MEM_BYTES (32'd12)
  ) dutSmall (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imemAddrSmall),
    .imem_instr     (imemInstrSmall),
    .redirect_valid (redirectValid),
    .redirect_pc    (redirectPc),
    .out_valid      (outValidSmall),
    .out_instr      (outInstrSmall),
    .out_pc         (outPcSmall),
    .out_ready      (outReady),
    .halted         (haltedSmall)
  );

  task automatic applyStimulus(input logic ready, input logic redir,
                               input logic [31:0] target);
    outReady      = ready;
    redirectValid = redir;
    redirectPc    = target;
  endtask

  // Advance n clock cycles and settle just after the rising edge.
  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle synchronous reset; returns in cycle 0 after release.
  task automatic doReset();
    reset = 1'b1;
    stepCycles(1);
    reset = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h0);
    stepCycles(3);
    reset = 1'b0;

    $display("[TB] scenario: basic fetch with out_ready=1");
    checkOutput("rst_valid", 32'(outValid), 32'd0);
    checkOutput("rst_addr", imemAddr, 32'h0);
    checkOutput("rst_halted", 32'(halted), 32'd0);
    stepCycles(2);
    checkOutput("c2_valid", 32'(outValid), 32'd0);
    stepCycles(1);
    checkOutput("c3_valid", 32'(outValid), 32'd1);
    checkOutput("c3_pc", outPc, 32'h0);
    checkOutput("c3_instr", outInstr, 32'h5800000F);
    checkOutput("c3_addr", imemAddr, 32'h4);
    stepCycles(1);
    checkOutput("c4_valid", 32'(outValid), 32'd0);
    stepCycles(2);
    checkOutput("c6_valid", 32'(outValid), 32'd1);
    checkOutput("c6_pc", outPc, 32'h4);
    checkOutput("c6_instr", outInstr, 32'h58080010);
    checkOutput("c6_addr", imemAddr, 32'h8);
    stepCycles(3);
    checkOutput("c9_valid", 32'(outValid), 32'd1);
    checkOutput("c9_pc", outPc, 32'h8);
    checkOutput("c9_instr", outInstr, 32'h10009000);
    checkOutput("c9_addr", imemAddr, 32'hC);
    checkOutput("c9_halted", 32'(halted), 32'd0);

    $display("[TB] scenario: end of 12-byte memory");
    checkOutput("small_c9_halted", 32'(haltedSmall), 32'd1);
    checkOutput("small_c9_addr", imemAddrSmall, 32'hC);
    checkOutput("small_c9_valid", 32'(outValidSmall), 32'd1);
    checkOutput("small_c9_pc", outPcSmall, 32'h8);
    stepCycles(1);
    checkOutput("small_c10_valid", 32'(outValidSmall), 32'd0);
    stepCycles(3);
    checkOutput("small_c13_valid", 32'(outValidSmall), 32'd0);
    checkOutput("small_c13_addr", imemAddrSmall, 32'hC);
    checkOutput("small_c13_halted", 32'(haltedSmall), 32'd1);

    $display("[TB] scenario: back-pressure into STALL");
    applyStimulus(1'b0, 1'b0, 32'h0);
    doReset();
    checkOutput("bp_rst_valid", 32'(outValid), 32'd0);
    stepCycles(3);
    checkOutput("bp_c3_valid", 32'(outValid), 32'd1);
    checkOutput("bp_c3_pc", outPc, 32'h0);
    stepCycles(6);
    checkOutput("bp_c9_addr", imemAddr, 32'h8);
    checkOutput("bp_c9_pc", outPc, 32'h0);
    stepCycles(3);
    checkOutput("bp_c12_addr", imemAddr, 32'h8);
    checkOutput("bp_c12_instr", outInstr, 32'h5800000F);
    applyStimulus(1'b1, 1'b0, 32'h0);
    stepCycles(1);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("bp_c13_pc", outPc, 32'h4);
    checkOutput("bp_c13_instr", outInstr, 32'h58080010);
    checkOutput("bp_c13_addr", imemAddr, 32'hC);
    stepCycles(1);
    checkOutput("bp_c14_pc", outPc, 32'h4);
    applyStimulus(1'b1, 1'b0, 32'h0);
    stepCycles(1);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("bp_c15_valid", 32'(outValid), 32'd1);
    checkOutput("bp_c15_pc", outPc, 32'h8);
    checkOutput("bp_c15_instr", outInstr, 32'h10009000);

    $display("[TB] scenario: redirect mid-wait");
    doReset();
    stepCycles(3);
    checkOutput("rd_c3_valid", 32'(outValid), 32'd1);
    stepCycles(1);
    applyStimulus(1'b0, 1'b1, 32'h6);
    stepCycles(1);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("rd_c5_valid", 32'(outValid), 32'd0);
    checkOutput("rd_c5_addr", imemAddr, 32'h4);
    checkOutput("rd_c5_halted", 32'(halted), 32'd0);
    stepCycles(2);
    checkOutput("rd_c7_valid", 32'(outValid), 32'd0);
    stepCycles(1);
    checkOutput("rd_c8_valid", 32'(outValid), 32'd1);
    checkOutput("rd_c8_pc", outPc, 32'h4);
    checkOutput("rd_c8_instr", outInstr, 32'h58080010);

    $display("[TB] scenario: redirect out of range and back");
    applyStimulus(1'b0, 1'b1, 32'h100);
    stepCycles(1);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("far_halted", 32'(halted), 32'd1);
    checkOutput("far_addr", imemAddr, 32'h100);
    checkOutput("far_valid", 32'(outValid), 32'd0);
    stepCycles(3);
    checkOutput("far_hold_halted", 32'(halted), 32'd1);
    checkOutput("far_hold_valid", 32'(outValid), 32'd0);
    checkOutput("far_hold_addr", imemAddr, 32'h100);
    applyStimulus(1'b0, 1'b1, 32'h0);
    stepCycles(1);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("back_halted", 32'(halted), 32'd0);
    checkOutput("back_addr", imemAddr, 32'h0);
    stepCycles(2);
    checkOutput("back_c2_valid", 32'(outValid), 32'd0);
    stepCycles(1);
    checkOutput("back_c3_valid", 32'(outValid), 32'd1);
    checkOutput("back_c3_pc", outPc, 32'h0);
    checkOutput("back_c3_instr", outInstr, 32'h5800000F);

    $display("[TB] scenario: reset while stalled");
    doReset();
    stepCycles(10);
    checkOutput("st_addr", imemAddr, 32'h8);
    checkOutput("st_valid", 32'(outValid), 32'd1);
    doReset();
    checkOutput("st_rst_valid", 32'(outValid), 32'd0);
    checkOutput("st_rst_addr", imemAddr, 32'h0);
    checkOutput("st_rst_halted", 32'(halted), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    stepCycles(2);
    checkOutput("st_c2_valid", 32'(outValid), 32'd0);
    stepCycles(1);
    checkOutput("st_c3_pc", outPc, 32'h0);
    checkOutput("st_c3_instr", outInstr, 32'h5800000F);
    stepCycles(3);
    checkOutput("st_c6_pc", outPc, 32'h4);
    checkOutput("st_c6_instr", outInstr, 32'h58080010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
